// File: rtl/chain_sequencer_if.sv
// Element request/response and result write-back bus between chain_sequencer and its chain stage.
// The sequencer takes the master side; the stage (or bench) takes the slave side.
interface chain_sequencer_if #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8
);
    localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

    logic               req_valid;
    logic               req_ready;
    logic [ROW_W-1:0]   req_row;
    logic [COL_W-1:0]   req_col;
    logic               rsp_valid;
    logic signed [31:0] rsp_data;
    logic               wr_en;
    logic [ROW_W-1:0]   wr_row;
    logic [COL_W-1:0]   wr_col;
    logic signed [31:0] wr_data;

    modport master (
        output req_valid, req_row, req_col, wr_en, wr_row, wr_col, wr_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_row, req_col, wr_en, wr_row, wr_col, wr_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/chain_sequencer.sv
// Row-major matrix walker: issues one element request at a time to a chain stage, writes each result back,
// repeats NUM_PASSES times per start. Optional running checksum output enabled by CHAIN_SEQ_CHECKSUM_EN.
module chain_sequencer #(
    parameter int SIZE_A     = 8,
    parameter int SIZE_B     = 8,
    parameter int NUM_PASSES = 1,
    localparam int PASS_W    = $clog2(NUM_PASSES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    chain_sequencer_if.master bus,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
`ifdef CHAIN_SEQ_CHECKSUM_EN
    ,
    output logic signed [31:0] checksum
`endif
);
    localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SIZE_A - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SIZE_B - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, FINISH} state_t;
    state_t state;

    logic last_col;
    logic last_row;
    logic last_pass;
    logic pass_end;

    // The request index registers double as the walk position.
    assign last_col  = (bus.req_col == COL_LAST);
    assign last_row  = (bus.req_row == ROW_LAST);
    assign last_pass = (pass_idx == PASS_LAST);
    assign pass_end  = last_col && last_row;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.req_valid <= 1'b0;
            bus.req_row   <= '0;
            bus.req_col   <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_row    <= '0;
            bus.wr_col    <= '0;
            bus.wr_data   <= '0;
            pass_idx      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= ISSUE;
                        bus.req_valid <= 1'b1;
                        bus.req_row   <= '0;
                        bus.req_col   <= '0;
                        pass_idx      <= '0;
                        busy          <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state         <= IDLE;
                        bus.req_valid <= 1'b0;
                        busy          <= 1'b0;
                    end else if (bus.req_ready) begin
                        state         <= WAIT_RSP;
                        bus.req_valid <= 1'b0;
                    end
                end
                WAIT_RSP: begin
                    // Abort wins over a coincident response: the result is dropped, not written.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bus.rsp_valid) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_row  <= bus.req_row;
                        bus.wr_col  <= bus.req_col;
                        bus.wr_data <= bus.rsp_data;
                        if (!last_col) begin
                            bus.req_col <= bus.req_col + COL_W'(1);
                        end else begin
                            bus.req_col <= '0;
                            if (!last_row) begin
                                bus.req_row <= bus.req_row + ROW_W'(1);
                            end else begin
                                bus.req_row <= '0;
                            end
                        end
                        if (pass_end && last_pass) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state         <= ISSUE;
                            bus.req_valid <= 1'b1;
                            if (pass_end) begin
                                pass_idx <= pass_idx + PASS_W'(1);
                            end
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHAIN_SEQ_CHECKSUM_EN
    // Restarting at a pass boundary means only the final pass's sum survives to done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (state == WAIT_RSP && bus.rsp_valid && !abort) begin
            if (pass_end && !last_pass) begin
                checksum <= '0;
            end else begin
                checksum <= checksum + bus.rsp_data;
            end
        end
    end
`endif

    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req_valid && !bus.req_ready && !abort) |=>
        (bus.req_valid && $stable(bus.req_row) && $stable(bus.req_col)));

    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> !busy);

    a_no_req_in_flight_write: assert property (@(posedge clk) disable iff (!rst_n)
        bus.wr_en |-> $past(state == WAIT_RSP));
endmodule

// File: tb/tb_chain_sequencer.sv
// Bench for chain_sequencer: stage timing driven randomly, expected writes taken from a row-major element list.
module tb_chain_sequencer;
    localparam int SA = 2;
    localparam int SB = 3;
    localparam int NP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, start1, abort1;
    logic [1:0] pass_idx;
    logic       busy, done;
    logic [0:0] pass_idx1;
    logic       busy1, done1;
`ifdef CHAIN_SEQ_CHECKSUM_EN
    logic signed [31:0] checksum, checksum1;
`endif
    int total = 0;
    int bad   = 0;

    chain_sequencer_if #(.SIZE_A(SA), .SIZE_B(SB)) bus ();
    chain_sequencer_if #(.SIZE_A(1), .SIZE_B(1)) bus1 ();

    chain_sequencer #(.SIZE_A(SA), .SIZE_B(SB), .NUM_PASSES(NP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus),
        .pass_idx(pass_idx), .busy(busy), .done(done)
`ifdef CHAIN_SEQ_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    chain_sequencer #(.SIZE_A(1), .SIZE_B(1), .NUM_PASSES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .bus(bus1),
        .pass_idx(pass_idx1), .busy(busy1), .done(done1)
`ifdef CHAIN_SEQ_CHECKSUM_EN
        , .checksum(checksum1)
`endif
    );

    // mode 0: always ready, response next cycle; 1: as 0 but stall (1,1) of pass 0 for 5 cycles;
    // 2: random ready, latency, spurious responses and start noise. exp_cyc=0 skips the latency check.
    task automatic run_dut(input string tag, input int mode, input bit fixed, input int exp_cyc);
        int er[$], ec[$], ep[$];
        logic signed [31:0] dq[$];
        logic signed [31:0] d, sum_last;
        int n, acc_n, wr_n, cyc, lat, stall, rr, rc, rp;
        bit outstanding, prev_valid, prev_ready, finished;
        logic [0:0] prev_row;
        logic [1:0] prev_col;
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < SA; r++)
                for (int c = 0; c < SB; c++) begin
                    ep.push_back(p); er.push_back(r); ec.push_back(c);
                end
        n = ep.size();
        acc_n = 0; wr_n = 0; cyc = 0; lat = 0; stall = 0; rr = 0; rc = 0; rp = 0;
        outstanding = 0; prev_valid = 0; prev_ready = 0; finished = 0; sum_last = 0;
        prev_row = '0; prev_col = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished && cyc <= 400) begin
            if (prev_valid && !prev_ready) begin
                total++;
                if (bus.req_valid !== 1'b1 || bus.req_row !== prev_row || bus.req_col !== prev_col) begin
                    bad++;
                    $display("FAIL %s req_hold cyc=%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)", tag, cyc,
                             bus.req_valid, bus.req_row, bus.req_col, prev_row, prev_col);
                end
            end
            if (bus.wr_en === 1'b1) begin
                total++;
                if (wr_n >= n || dq.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_write cyc=%0d got write #%0d want at most %0d", tag, cyc, wr_n + 1, n);
                end else begin
                    d = dq.pop_front();
                    if (bus.wr_row !== er[wr_n] || bus.wr_col !== ec[wr_n] || bus.wr_data !== d) begin
                        bad++;
                        $display("FAIL %s write#%0d got (%0d,%0d)=%0d want (%0d,%0d)=%0d", tag, wr_n,
                                 bus.wr_row, bus.wr_col, bus.wr_data, er[wr_n], ec[wr_n], d);
                    end
                end
                wr_n++;
            end
            if (done === 1'b1) begin
                finished = 1;
                total++;
                if (wr_n != n || (exp_cyc > 0 && cyc != exp_cyc) || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done got writes=%0d cyc=%0d busy=%b want writes=%0d cyc=%0d busy=0",
                             tag, wr_n, cyc, busy, n, exp_cyc);
                end
`ifdef CHAIN_SEQ_CHECKSUM_EN
                total++;
                if (checksum !== sum_last) begin
                    bad++;
                    $display("FAIL %s checksum got %0d want %0d", tag, checksum, sum_last);
                end
`endif
            end else begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy cyc=%0d got %b want 1", tag, cyc, busy);
                end
            end
            if (!finished) begin
                bus.rsp_valid = 1'b0;
                if (outstanding) begin
                    if (lat == 0) begin
                        d = fixed ? (10 * rr + rc) : $urandom;
                        bus.rsp_valid = 1'b1;
                        bus.rsp_data  = d;
                        dq.push_back(d);
                        if (rp == NP - 1) sum_last += d;
                        outstanding = 0;
                    end else begin
                        lat--;
                    end
                end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = $urandom;
                end
                bus.req_ready = 1'b0;
                if (bus.req_valid === 1'b1) begin
                    if (mode == 0) bus.req_ready = 1'b1;
                    else if (mode == 1) begin
                        if (acc_n < n && ep[acc_n] == 0 && er[acc_n] == 1 && ec[acc_n] == 1 && stall < 5) stall++;
                        else bus.req_ready = 1'b1;
                    end else bus.req_ready = ($urandom_range(0, 2) != 0);
                    if (bus.req_ready) begin
                        total++;
                        if (acc_n >= n || bus.req_row !== er[acc_n] || bus.req_col !== ec[acc_n] ||
                            pass_idx !== ep[acc_n]) begin
                            bad++;
                            $display("FAIL %s accept#%0d got p%0d (%0d,%0d) want p%0d (%0d,%0d)", tag, acc_n,
                                     pass_idx, bus.req_row, bus.req_col,
                                     (acc_n < n) ? ep[acc_n] : -1, (acc_n < n) ? er[acc_n] : -1,
                                     (acc_n < n) ? ec[acc_n] : -1);
                        end
                        if (acc_n < n) begin
                            rr = er[acc_n]; rc = ec[acc_n]; rp = ep[acc_n];
                        end
                        acc_n++;
                        outstanding = 1;
                        lat = (mode == 2) ? $urandom_range(0, 3) : 0;
                    end
                end else if (mode == 2) begin
                    bus.req_ready = 1'($urandom_range(0, 1));
                end
                start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_valid = bus.req_valid;
                prev_ready = bus.req_ready;
                prev_row   = bus.req_row;
                prev_col   = bus.req_col;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!finished) begin
            total++; bad++;
            $display("FAIL %s timeout got no done within %0d cycles want done", tag, cyc);
        end
        start = 1'b0; bus.req_ready = 1'b0; bus.rsp_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.req_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s post_done got done=%b busy=%b req_valid=%b want 0 0 0", tag, done, busy, bus.req_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
        bus1.req_ready = 1'b0; bus1.rsp_valid = 1'b0; bus1.rsp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.req_valid, bus.req_row, bus.req_col, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, pass_idx} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b (%0d,%0d) wr=%b (%0d,%0d) d=%0d p=%0d want all 0", bus.req_valid,
                     bus.req_row, bus.req_col, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, pass_idx);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_status got busy=%b done=%b want 0 0", busy, done);
        end
        total++;
        if ({bus1.req_valid, bus1.wr_en, bus1.wr_data, pass_idx1, busy1, done1} !== '0) begin
            bad++;
            $display("FAIL reset_single got v=%b wr=%b d=%0d busy=%b done=%b want 0", bus1.req_valid, bus1.wr_en,
                     bus1.wr_data, busy1, done1);
        end
`ifdef CHAIN_SEQ_CHECKSUM_EN
        total++;
        if (checksum !== 0) begin
            bad++;
            $display("FAIL reset_checksum got %0d want 0", checksum);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || bus.req_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b req_valid=%b want 0 0", busy, bus.req_valid);
        end
    endtask

    task automatic test_nominal();
        run_dut("nominal", 0, 1'b1, 24);
    endtask

    task automatic test_back_to_back();
        run_dut("b2b_a", 0, 1'b1, 24);
        run_dut("b2b_b", 2, 1'b0, 0);
    endtask

    task automatic test_stall();
        run_dut("stall", 1, 1'b1, 29);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) run_dut("random", 2, 1'b0, 0);
    endtask

    task automatic test_abort();
        bit pend, got, bad_seen;
        int cyc;
        // Abort while the first request is still waiting for ready.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1; bus.req_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; bus.req_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || bus.req_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_issue got busy=%b req_valid=%b done=%b want 0 0 0", busy, bus.req_valid, done);
        end
        // Abort in WAIT_RSP of (0,2), coincident with its response.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus.req_ready = 1'b1;
        pend = 0; got = 0; cyc = 0;
        while (!got && cyc < 40) begin
            bus.rsp_valid = 1'b0;
            if (pend) begin
                bus.rsp_valid = 1'b1; bus.rsp_data = 32'sd99; pend = 0;
                if (bus.req_row === 1'b0 && bus.req_col === 2'd2) begin
                    abort = 1'b1; got = 1;
                end
            end else if (bus.req_valid === 1'b1) begin
                pend = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b0; bus.rsp_valid = 1'b0; bus.req_ready = 1'b0;
        total++;
        if (!got || bus.wr_en !== 1'b0 || busy !== 1'b0 || bus.req_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_wait got reached=%b wr_en=%b busy=%b req_valid=%b done=%b want 1 0 0 0 0", got,
                     bus.wr_en, busy, bus.req_valid, done);
        end
        bad_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || bus.wr_en !== 1'b0 || busy !== 1'b0) bad_seen = 1;
        end
        total++;
        if (bad_seen) begin
            bad++;
            $display("FAIL abort_quiet got activity after abort want none");
        end
    endtask

    task automatic test_mid_reset();
        bit pend, bad_seen;
        int cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus.req_ready = 1'b1;
        pend = 0; cyc = 0;
        while (!(pend && pass_idx === 2'd1 && bus.req_row === 1'b1) && cyc < 100) begin
            bus.rsp_valid = 1'b0;
            if (pend) begin
                bus.rsp_valid = 1'b1; bus.rsp_data = 32'sd7; pend = 0;
            end else if (bus.req_valid === 1'b1) begin
                pend = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc >= 100) begin
            bad++;
            $display("FAIL mid_reset_reach got no pass 1 wait within %0d cycles want reached", cyc);
        end
        rst_n = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_data = 32'sd5;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if ({bus.req_valid, bus.req_row, bus.req_col, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data,
             pass_idx, busy, done} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got v=%b (%0d,%0d) wr=%b d=%0d p=%0d busy=%b done=%b want all 0",
                     bus.req_valid, bus.req_row, bus.req_col, bus.wr_en, bus.wr_data, pass_idx, busy, done);
        end
        bad_seen = 0;
        for (int i = 0; i < 4; i++) begin
            bus.rsp_valid = ~bus.rsp_valid;
            @(posedge clk); #1;
            if (done !== 1'b0 || bus.wr_en !== 1'b0 || busy !== 1'b0 || bus.req_valid !== 1'b0) bad_seen = 1;
        end
        bus.rsp_valid = 1'b0; bus.req_ready = 1'b0;
        total++;
        if (bad_seen) begin
            bad++;
            $display("FAIL mid_reset_quiet got activity after reset want none");
        end
`ifdef CHAIN_SEQ_CHECKSUM_EN
        total++;
        if (checksum !== 0) begin
            bad++;
            $display("FAIL mid_reset_checksum got %0d want 0", checksum);
        end
`endif
        run_dut("after_reset", 0, 1'b1, 24);
    endtask

    task automatic test_single();
        bit pend;
        int wr, dn, dcyc;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; bus1.req_ready = 1'b1;
        pend = 0; wr = 0; dn = 0; dcyc = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (bus1.wr_en === 1'b1) begin
                wr++;
                total++;
                if (bus1.wr_row !== 1'b0 || bus1.wr_col !== 1'b0 || bus1.wr_data !== 32'sd77) begin
                    bad++;
                    $display("FAIL single_write got (%0d,%0d)=%0d want (0,0)=77", bus1.wr_row, bus1.wr_col,
                             bus1.wr_data);
                end
            end
            if (done1 === 1'b1) begin
                dn++; dcyc = cyc;
            end
            bus1.rsp_valid = 1'b0;
            if (pend) begin
                bus1.rsp_valid = 1'b1; bus1.rsp_data = 32'sd77; pend = 0;
            end else if (bus1.req_valid === 1'b1) begin
                pend = 1;
            end
            @(posedge clk); #1;
        end
        bus1.req_ready = 1'b0; bus1.rsp_valid = 1'b0;
        total++;
        if (wr != 1 || dn != 1 || dcyc != 2) begin
            bad++;
            $display("FAIL single_run got writes=%0d dones=%0d done_cyc=%0d want 1 1 2", wr, dn, dcyc);
        end
`ifdef CHAIN_SEQ_CHECKSUM_EN
        total++;
        if (checksum1 !== 32'sd77) begin
            bad++;
            $display("FAIL single_checksum got %0d want 77", checksum1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_stall();
        test_random();
        test_abort();
        test_mid_reset();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
